// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the unified instruction/data memory.
// Port 0 is the core, port 1 the debug/loader master; an owner may lock for a bounded burst.
module mem_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_lock,
    input  logic [AW-1:0] p0_adr,
    input  logic [DW-1:0] p0_wd,
    output logic          p0_gnt,
    output logic [DW-1:0] p0_rd,
    output logic          p0_rvalid,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_adr,
    input  logic [DW-1:0] p1_wd,
    output logic          p1_gnt,
    output logic [DW-1:0] p1_rd,
    output logic          p1_rvalid,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic [1:0]    owner
);

    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [DW-1:0]  rd0_q, rd1_q;
    logic           rv0_q, rv1_q;

    // Owner/other view of the two ports so both OWN states share one rule set.
    logic own1, x_req, x_lock, o_req;
    assign own1   = (state_q == OWN1);
    assign x_req  = own1 ? p1_req  : p0_req;
    assign x_lock = own1 ? p1_lock : p0_lock;
    assign o_req  = own1 ? p0_req  : p1_req;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = '0;
        case (state_q)
            IDLE: begin
                if (p0_req && p1_req) state_d = last_q ? OWN0 : OWN1;
                else if (p0_req)      state_d = OWN0;
                else if (p1_req)      state_d = OWN1;
            end
            OWN0, OWN1: begin
                last_d = own1;
                if (x_req && x_lock && (!o_req || hold_q < HOLD_LIM)) begin
                    if (o_req) hold_d = hold_q + HW'(1);
                end else if (o_req) begin
                    state_d = own1 ? OWN0 : OWN1;
                end else if (!x_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign p0_gnt = (state_q == OWN0);
    assign p1_gnt = (state_q == OWN1);
    assign owner  = state_q;

    always_comb begin
        mem_we  = 1'b0;
        mem_adr = '0;
        mem_wd  = '0;
        if (p0_gnt) begin
            mem_we  = p0_req & p0_we;
            mem_adr = p0_adr;
            mem_wd  = p0_wd;
        end else if (p1_gnt) begin
            mem_we  = p1_req & p1_we;
            mem_adr = p1_adr;
            mem_wd  = p1_wd;
        end
    end

    logic rd0_xfer, rd1_xfer;
    assign rd0_xfer = p0_gnt & p0_req & ~p0_we;
    assign rd1_xfer = p1_gnt & p1_req & ~p1_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd0_q <= '0;
            rd1_q <= '0;
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
        end else begin
            rv0_q <= rd0_xfer;
            rv1_q <= rd1_xfer;
            if (rd0_xfer) rd0_q <= mem_rd;
            if (rd1_xfer) rd1_q <= mem_rd;
        end
    end

    assign p0_rd     = rd0_q;
    assign p1_rd     = rd1_q;
    assign p0_rvalid = rv0_q;
    assign p1_rvalid = rv1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a cycle model.
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MAX_HOLD = 8;

    logic          clk, reset;
    logic          p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
    logic [AW-1:0] p0_adr, p1_adr, mem_adr;
    logic [DW-1:0] p0_wd, p1_wd, p0_rd, p1_rd, mem_wd, mem_rd;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we;
    logic [1:0]    owner;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.DW(DW), .AW(AW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_adr(p0_adr), .p0_wd(p0_wd),
        .p0_gnt(p0_gnt), .p0_rd(p0_rd), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_adr(p1_adr), .p1_wd(p1_wd),
        .p1_gnt(p1_gnt), .p1_rd(p1_rd), .p1_rvalid(p1_rvalid),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        p0_req = 0; p0_we = 0; p0_lock = 0; p0_adr = '0; p0_wd = '0;
        p1_req = 0; p1_we = 0; p1_lock = 0; p1_adr = '0; p1_wd = '0;
        mem_rd = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            p0_req = 1'($urandom); p0_we = 1'($urandom); p0_lock = 1'($urandom);
            p1_req = 1'($urandom); p1_we = 1'($urandom); p1_lock = 1'($urandom);
            p0_adr = $urandom; p0_wd = $urandom; p1_adr = $urandom; p1_wd = $urandom;
            mem_rd = $urandom;
            #1;
            n_cmp++;
            if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we} !== 5'b0 || owner !== 2'd0
                || mem_adr !== '0 || p0_rd !== '0 || p1_rd !== '0) begin
                n_bad++;
                $display("FAIL reset_hold: gnt=%b%b rv=%b%b we=%b owner=%0d adr=%h expected all 0",
                         p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_we, owner, mem_adr);
            end
        end
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (owner !== 2'd0 || p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_idle: owner=%0d gnt=%b%b expected 0 00", owner, p0_gnt, p1_gnt);
        end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        p0_req = 1; p0_we = 1; p0_adr = 32'h10; p0_wd = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        n_cmp++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || mem_we !== 1'b1
            || mem_adr !== 32'h10 || mem_wd !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL single_write: gnt=%b%b we=%b adr=%h wd=%h expected 10 1 00000010 deadbeef",
                     p0_gnt, p1_gnt, mem_we, mem_adr, mem_wd);
        end
    endtask

    task automatic test_idle_return();
        p0_req = 0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (owner !== 2'd0 || mem_we !== 1'b0 || mem_adr !== '0 || p0_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_return: owner=%0d we=%b adr=%h gnt0=%b expected 0 0 0 0",
                     owner, mem_we, mem_adr, p0_gnt);
        end
        clear_inputs();
    endtask

    task automatic test_contention();
        logic [DW-1:0] prev_rd;
        bit            prev_p1;
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        p0_req = 1; p1_req = 1;
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (p0_gnt !== 1'(k % 2 == 0) || p1_gnt !== 1'(k % 2 == 1)) begin
                n_bad++;
                $display("FAIL contention_grant[%0d]: gnt=%b%b expected %b%b",
                         k, p0_gnt, p1_gnt, 1'(k % 2 == 0), 1'(k % 2 == 1));
            end
            if (k > 0) begin
                n_cmp++;
                if (prev_p1 && (p1_rvalid !== 1'b1 || p1_rd !== 32'h12345678 || p0_rvalid !== 1'b0)) begin
                    n_bad++;
                    $display("FAIL contention_p1_read[%0d]: rv=%b%b rd1=%h expected rv=01 rd1=12345678",
                             k, p0_rvalid, p1_rvalid, p1_rd);
                end else if (!prev_p1 && (p0_rvalid !== 1'b1 || p0_rd !== prev_rd || p1_rvalid !== 1'b0)) begin
                    n_bad++;
                    $display("FAIL contention_p0_read[%0d]: rv=%b%b rd0=%h expected rv=10 rd0=%h",
                             k, p0_rvalid, p1_rvalid, p0_rd, prev_rd);
                end
            end
            prev_p1 = (k % 2 == 1);
            prev_rd = prev_p1 ? 32'h12345678 : (32'h0BAD0000 | DW'(k));
            mem_rd  = prev_rd;
        end
        clear_inputs();
    endtask

    task automatic test_lock_bound();
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        p1_req = 1; p1_lock = 1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        p0_req = 1;
        for (int i = 0; i < MAX_HOLD; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            n_cmp++;
            if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin
                n_bad++;
                $display("FAIL lock_hold[%0d]: gnt=%b%b expected 01", i, p0_gnt, p1_gnt);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_yield: gnt=%b%b expected 10", p0_gnt, p1_gnt);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_return: gnt=%b%b expected 01", p0_gnt, p1_gnt);
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        p1_req = 1; p1_we = 1; p1_adr = 32'h44; p1_wd = 32'hCAFEF00D;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (p1_gnt !== 1'b1 || mem_we !== 1'b1) begin
            n_bad++;
            $display("FAIL async_pre: gnt1=%b we=%b expected 1 1", p1_gnt, mem_we);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (p1_gnt !== 1'b0 || mem_we !== 1'b0 || owner !== 2'd0) begin
            n_bad++;
            $display("FAIL async_drop: gnt1=%b we=%b owner=%0d expected 0 0 0", p1_gnt, mem_we, owner);
        end
        p0_req = 1; p1_we = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
            n_bad++;
            $display("FAIL async_first_grant: gnt=%b%b expected 10", p0_gnt, p1_gnt);
        end
        clear_inputs();
    endtask

    // Model: who holds the memory, who wins the next tie, and how many cycles the
    // holder has kept it while the other port was waiting.
    task automatic test_random();
        int            own, prefer, waited, x, o;
        bit [1:0]      rq, lk, wr, m_rv, e_gnt;
        logic [DW-1:0] m_rd [2];
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_wd;
        bit            e_we;
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        own = 0; prefer = 0; waited = 0; m_rv = '0; m_rd[0] = '0; m_rd[1] = '0;
        for (int c = 0; c < 400; c++) begin
            rq = {1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0)};
            lk = (c % 100 < 50) ? 2'($urandom) : 2'b11;
            wr = 2'($urandom);
            p0_req = rq[0]; p0_lock = lk[0]; p0_we = wr[0]; p0_adr = $urandom; p0_wd = $urandom;
            p1_req = rq[1]; p1_lock = lk[1]; p1_we = wr[1]; p1_adr = $urandom; p1_wd = $urandom;
            mem_rd = $urandom;
            #1;
            e_gnt = (own == 0) ? 2'b00 : 2'(1 << (own - 1));
            e_we  = 1'b0; e_adr = '0; e_wd = '0;
            if (own == 1) begin e_we = rq[0] & wr[0]; e_adr = p0_adr; e_wd = p0_wd; end
            if (own == 2) begin e_we = rq[1] & wr[1]; e_adr = p1_adr; e_wd = p1_wd; end
            n_cmp++;
            if ({p1_gnt, p0_gnt} !== e_gnt || owner !== 2'(own) || mem_we !== e_we
                || mem_adr !== e_adr || mem_wd !== e_wd) begin
                n_bad++;
                $display("FAIL rand_grant[%0d]: gnt=%b%b owner=%0d we=%b adr=%h wd=%h expected gnt=%b owner=%0d we=%b adr=%h wd=%h",
                         c, p1_gnt, p0_gnt, owner, mem_we, mem_adr, mem_wd, e_gnt, own, e_we, e_adr, e_wd);
            end
            n_cmp++;
            if ({p1_rvalid, p0_rvalid} !== m_rv || p0_rd !== m_rd[0] || p1_rd !== m_rd[1]) begin
                n_bad++;
                $display("FAIL rand_read[%0d]: rv=%b%b rd=%h/%h expected rv=%b rd=%h/%h",
                         c, p1_rvalid, p0_rvalid, p0_rd, p1_rd, m_rv, m_rd[0], m_rd[1]);
            end
            for (int p = 0; p < 2; p++) begin
                m_rv[p] = (own == p + 1) && rq[p] && !wr[p];
                if (m_rv[p]) m_rd[p] = mem_rd;
            end
            if (own == 0) begin
                if (rq == 2'b11) own = prefer + 1;
                else if (rq[0])  own = 1;
                else if (rq[1])  own = 2;
                waited = 0;
            end else begin
                x = own - 1; o = 1 - x;
                prefer = o;
                if (rq[x] && lk[x] && (!rq[o] || waited + 1 < MAX_HOLD)) begin
                    waited = rq[o] ? waited + 1 : 0;
                end else begin
                    waited = 0;
                    if (rq[o])       own = o + 1;
                    else if (!rq[x]) own = 0;
                end
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_write();
        test_idle_return();
        test_contention();
        test_lock_bound();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters:
  - port 0: the multi-cycle core's memory interface (Adr/WriteData/MemWrite/ReadData path);
  - port 1: the debug/program-loader master.
- Registered round-robin arbiter with an optional bounded lock for back-to-back sequences.
- Sits between the requesters and the memory; drives the memory's we/a/wd pins and returns read data to the owner.

Parameters:
- DW, 32, data width.
- AW, 32, address width.
- MAX_HOLD, 8, maximum consecutive grant cycles a locked owner keeps the memory while the other port requests (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 access request.
- p0_we  in  1  port 0 write enable (1=write, 0=read).
- p0_lock  in  1  port 0 requests to keep ownership.
- p0_adr  in  AW  port 0 address.
- p0_wd  in  DW  port 0 write data.
- p0_gnt  out  1  port 0 owns the memory this cycle.
- p0_rd  out  DW  port 0 read data (registered).
- p0_rvalid  out  1  p0_rd valid this cycle.
- p1_req, p1_we, p1_lock, p1_adr, p1_wd, p1_gnt, p1_rd, p1_rvalid: same as port 0, for port 1.
- mem_we  out  1  -> memory we.
- mem_adr  out  AW  -> memory a.
- mem_wd  out  DW  -> memory wd.
- mem_rd  in  DW  memory rd; combinational read of mem_adr.
- owner  out  2  visualizer: 0=IDLE, 1=OWN0, 2=OWN1.

Behaviour:
- State machine: IDLE, OWN0, OWN1.
  - State register, last-served pointer `last` (1 bit), hold counter `hold_cnt` (clog2(MAX_HOLD)+1 bits).
- Reset (reset=0, asynchronous): IDLE, last=1 (port 0 wins first tie), hold_cnt=0; all outputs 0.
  - Mid-operation reset drops pX_gnt and mem_we immediately, without waiting for a clock edge.
- Grant and memory drive:
  - p0_gnt=(state==OWN0); p1_gnt=(state==OWN1); both are decoded from the registered state.
  - In OWNx the memory is driven from port x: mem_adr=px_adr, mem_wd=px_wd, mem_we=px_req&px_we.
  - In IDLE, mem_adr, mem_wd and mem_we are all 0.
- Transfer:
  - One transfer occurs on each rising edge where px_gnt=1 and px_req=1.
  - A requester holds px_req/we/adr/wd stable until that edge.
- Latency:
  - A request raised from IDLE is granted the next cycle.
  - Read data is registered: on a read transfer edge, px_rd<=mem_rd and px_rvalid<=1 in the following cycle.
  - rvalid is 0 otherwise; px_rd holds its last value.
- Next state, evaluated every edge (o = other port):
  - IDLE: both req -> OWN of port != last; one req -> OWN of that port; none -> IDLE.
  - OWNx, stay-locked condition: px_req & px_lock & (!po_req | hold_cnt < MAX_HOLD-1) -> stay OWNx.
  - Otherwise, if po_req -> OWNo.
  - Otherwise, if px_req -> stay OWNx.
  - Otherwise -> IDLE.
- last <= x whenever state is OWNx.
- hold_cnt:
  - Increments when OWNx stays OWNx while po_req=1 and px_lock=1.
  - Clears to 0 on any ownership change, on entry to IDLE, or when po_req=0.
- Fairness:
  - Without lock, two continuously requesting ports alternate every cycle.
  - A single requester is granted every cycle back-to-back.
  - A locked owner yields after exactly MAX_HOLD consecutive grant cycles while the other port requests.
- Owner dropping px_req while granted: no write that cycle; state follows the rules above.
- Simultaneous req rise from IDLE after reset: port 0 granted first.
- owner output mirrors the state encoding.

Test Plan:
- Reset: hold reset=0 with random inputs -> all gnt/rvalid/mem_we=0, owner=0; release -> owner=0 while no req.
- Single write: p0_req=1, p0_we=1, p0_adr=0x10, p0_wd=0xDEADBEEF at cycle 0 -> cycle 1: p0_gnt=1, mem_we=1, mem_adr=0x10, mem_wd=0xDEADBEEF; p1_gnt=0.
- Contention, no lock: both read continuously from reset -> grants p0,p1,p0,p1...; mem_rd=0x12345678 during a p1 grant -> next cycle p1_rvalid=1, p1_rd=0x12345678, p0_rvalid=0.
- Lock bound, MAX_HOLD=8: p1 owns with p1_lock=1, p1_req=1, then p0_req rises -> p1_gnt for exactly 8 consecutive cycles, then p0_gnt=1 for one cycle, then back to p1.
- Idle return: owner drops req with other port idle -> next cycle owner=0, mem_we=0, mem_adr=0.
- Async reset mid-write: reset falls between edges while OWN1 with p1_we=1 -> p1_gnt and mem_we go 0 immediately; after release with both req -> p0 granted first.
